// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the seven-segment display arbiter:
//   - state_e   : arbiter FSM states (IDLE, OWN0, OWN1)
//   - SEG_FONT  : hex digit -> segment pattern table, bit 6 = A .. bit 0 = G,
//                 active-high (1 = lit)
//   - SEG_BLANK : all segments dark
// -----------------------------------------------------------------------------
package seg_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_e;

   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   localparam logic [6:0] SEG_FONT [16] = '{
      7'b1111110,   // 0
      7'b0110000,   // 1
      7'b1101101,   // 2
      7'b1111001,   // 3
      7'b0110011,   // 4
      7'b1011011,   // 5
      7'b1011111,   // 6
      7'b1110000,   // 7
      7'b1111111,   // 8
      7'b1110011,   // 9
      7'b1110111,   // A
      7'b0011111,   // b
      7'b1001110,   // C
      7'b0111101,   // d
      7'b1001111,   // E
      7'b1000111    // F
   };

endpackage

// File: rtl/hex_to_seg7.sv
// -----------------------------------------------------------------------------
// hex_to_seg7
// Purely combinational hex nibble to seven-segment decoder using the shared
// seg_pkg font table.
// Ports:
//   i_nibble  in  4  hex value 0..F
//   o_seg     out 7  segments A..G, A = bit 6, active-high
// -----------------------------------------------------------------------------
module hex_to_seg7
   import seg_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);

   assign o_seg = SEG_FONT[i_nibble];

endmodule

// File: rtl/seg_display_arbiter.sv
// -----------------------------------------------------------------------------
// seg_display_arbiter
// Shares one 4-digit multiplexed seven-segment display between two
// requesters. Ownership is granted round-robin with a minimum dwell time,
// and the owner's 16-bit value is scanned one hex digit at a time onto the
// shared segment/anode pins.
//
// Parameters:
//   SCAN_DIV     clk cycles per digit slot
//   HOLD_CYCLES  minimum ownership time in clk cycles (>= 1)
//
// Ports:
//   clk           in   1   clock
//   rst           in   1   synchronous, active-high reset
//   req0, req1    in   1   ownership request (level)
//   data0, data1  in   16  hex value per requester, nibble 0 = rightmost
//   gnt0, gnt1    out  1   ownership grant, at most one high
//   seg           out  7   segments A..G, A = bit 6, active-high
//   an            out  4   digit enables, active-low, an[0] = rightmost
//   dp            out  1   decimal point, tied low
//
// Build option:
//   SEG_ARB_BLANK_ZERO_EN  when defined, leading zeros on digits 1..3 are
//                          blanked (anodes still scan).
// -----------------------------------------------------------------------------
module seg_display_arbiter
   import seg_pkg::*;
#(
   parameter int SCAN_DIV    = 100000,
   parameter int HOLD_CYCLES = 100000000
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic [15:0] data0,
   input  logic [15:0] data1,
   output logic        gnt0,
   output logic        gnt1,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic        dp
);

   // A divider of 1 would give a zero-width counter; keep at least one bit.
   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_e              r_state;
   logic                r_last_owner;   // index of the requester served last
   logic [HOLD_W-1:0]   r_hold_cnt;
   logic [SCAN_W-1:0]   r_scan_cnt;
   logic [1:0]          r_digit;
   logic [15:0]         r_disp_val;
   logic [6:0]          r_seg;
   logic [3:0]          r_an;

   state_e              w_next_state;
   logic                w_hold_done;
   logic                w_state_change;
   logic                w_release;
   logic [3:0]          w_nibble;
   logic [6:0]          w_seg_font;
   logic                w_blank;
   logic [6:0]          w_seg_shown;

   assign w_hold_done    = (r_hold_cnt == HOLD_MAX);
   assign w_state_change = (w_next_state != r_state);
   assign w_release      = (r_state != IDLE) && w_state_change;

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   // NOTE: w_next_state gets a default before the case so every path assigns
   // it; a missing branch would otherwise infer a latch.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (req0 && req1) begin
               // Contention: serve whoever was not served last.
               w_next_state = r_last_owner ? OWN0 : OWN1;
            end else if (req0) begin
               w_next_state = OWN0;
            end else if (req1) begin
               w_next_state = OWN1;
            end
         end
         OWN0: begin
            if (!req0 && w_hold_done) begin
               w_next_state = req1 ? OWN1 : IDLE;
            end
         end
         OWN1: begin
            if (!req1 && w_hold_done) begin
               w_next_state = req0 ? OWN0 : IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Digit mux, decode and optional leading-zero blanking
   // ---------------------------------------------------------------------
   always_comb begin
      w_nibble = r_disp_val[3:0];
      case (r_digit)
         2'd0: w_nibble = r_disp_val[3:0];
         2'd1: w_nibble = r_disp_val[7:4];
         2'd2: w_nibble = r_disp_val[11:8];
         2'd3: w_nibble = r_disp_val[15:12];
         default: w_nibble = r_disp_val[3:0];
      endcase
   end

   hex_to_seg7 u_hex_to_seg7 (
      .i_nibble (w_nibble),
      .o_seg    (w_seg_font)
   );

`ifdef SEG_ARB_BLANK_ZERO_EN
   // Digit k is dark when it and every digit to its left are zero; the
   // rightmost digit always shows so a zero value still reads "0".
   always_comb begin
      w_blank = 1'b0;
      case (r_digit)
         2'd1: w_blank = (r_disp_val[15:4]  == 12'h000);
         2'd2: w_blank = (r_disp_val[15:8]  == 8'h00);
         2'd3: w_blank = (r_disp_val[15:12] == 4'h0);
         default: w_blank = 1'b0;
      endcase
   end
`else
   assign w_blank = 1'b0;
`endif

   assign w_seg_shown = w_blank ? SEG_BLANK : w_seg_font;

   // ---------------------------------------------------------------------
   // Sequential logic
   // ---------------------------------------------------------------------
   // NOTE: all state below uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_last_owner <= 1'b1;
         r_hold_cnt   <= '0;
         r_scan_cnt   <= '0;
         r_digit      <= 2'd0;
         r_disp_val   <= 16'h0000;
         r_seg        <= SEG_BLANK;
         r_an         <= 4'b1111;
      end else begin
         r_state <= w_next_state;

         if (w_release) begin
            r_last_owner <= (r_state == OWN1);
         end

         // Restarts on every state entry and saturates, so the release
         // check is a simple equality no matter how long the owner stays.
         if (w_state_change) begin
            r_hold_cnt <= '0;
         end else if (!w_hold_done) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
         end

         // The owner's value tracks live data while it keeps requesting and
         // freezes once it lets go during the remaining dwell time.
         if (w_next_state == IDLE) begin
            r_disp_val <= 16'h0000;
         end else if (r_state == OWN0 && req0) begin
            r_disp_val <= data0;
         end else if (r_state == OWN1 && req1) begin
            r_disp_val <= data1;
         end

         // Scan runs in every state so the digit phase is independent of
         // ownership changes.
         if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt <= '0;
            r_digit    <= r_digit + 2'd1;
         end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
         end

         if (r_state == IDLE) begin
            r_an  <= 4'b1111;
            r_seg <= SEG_BLANK;
         end else begin
            r_an  <= ~(4'b0001 << r_digit);
            r_seg <= w_seg_shown;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign gnt0 = (r_state == OWN0);
   assign gnt1 = (r_state == OWN1);
   assign seg  = r_seg;
   assign an   = r_an;
   assign dp   = 1'b0;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// -----------------------------------------------------------------------------
// tb_seg_display_arbiter
// Scoreboard bench: the stimulus process advances a behavioural model of the
// arbiter on every clock edge and queues the outputs the display should show
// after that edge; a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seg_display_arbiter;

   localparam int SCAN_DIV    = 4;
   localparam int HOLD_CYCLES = 8;

   typedef struct packed {
      logic       g0;
      logic       g1;
      logic [6:0] seg;
      logic [3:0] an;
      logic       dp;
   } exp_t;

   // Segment patterns for 0..F, A = bit 6.
   localparam logic [6:0] FONT [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
   };

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, req1;
   logic [15:0] data0, data1;
   logic        gnt0, gnt1;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        dp;

   int n_checks = 0;
   int n_fail   = 0;
   int n_cycle  = 0;

   exp_t exp_q[$];

   // Behavioural model: who owns the display, for how long, what it shows,
   // and how many cycles the scan has run since reset.
   int          m_owner;   // 0 = nobody, 1 = requester 0, 2 = requester 1
   int          m_last;    // requester index served last
   int          m_held;    // cycles since ownership began
   int          m_tick;    // cycles since reset
   logic [15:0] m_disp;

   always #5 clk = ~clk;

   seg_display_arbiter #(
      .SCAN_DIV    (SCAN_DIV),
      .HOLD_CYCLES (HOLD_CYCLES)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .req0  (req0),
      .req1  (req1),
      .data0 (data0),
      .data1 (data1),
      .gnt0  (gnt0),
      .gnt1  (gnt1),
      .seg   (seg),
      .an    (an),
      .dp    (dp)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act[13:0], exp[13:0]);
      end
   endtask

   function automatic logic req_of(input int idx);
      return (idx == 0) ? req0 : req1;
   endfunction

   // Advance the model across one clock edge and queue what the outputs
   // must read afterwards.
   task automatic model_step();
      exp_t e;
      int   dig;
      int   nxt;
      int   x;
      logic [15:0] upper;
      e = '0;
      if (rst) begin
         m_owner = 0;
         m_last  = 1;
         m_held  = 0;
         m_tick  = 0;
         m_disp  = 16'h0000;
         e.an    = 4'b1111;
      end else begin
         // Outputs are registered: they show the pre-edge owner and digit.
         dig = (m_tick / SCAN_DIV) % 4;
         if (m_owner == 0) begin
            e.an  = 4'b1111;
            e.seg = 7'b0;
         end else begin
            e.an  = ~(4'b0001 << dig);
            e.seg = FONT[(m_disp >> (4 * dig)) & 16'hF];
`ifdef SEG_ARB_BLANK_ZERO_EN
            upper = m_disp >> (4 * dig);
            if (dig > 0 && upper == 16'h0) e.seg = 7'b0;
`else
            upper = 16'h0;
`endif
         end

         nxt = m_owner;
         if (m_owner == 0) begin
            if (req0 && req1) nxt = (m_last == 1) ? 1 : 2;
            else if (req0)    nxt = 1;
            else if (req1)    nxt = 2;
         end else begin
            x = m_owner - 1;
            if (!req_of(x) && m_held >= HOLD_CYCLES) begin
               m_last = x;
               nxt    = req_of(1 - x) ? (2 - x) : 0;
            end
         end

         if (nxt == 0)
            m_disp = 16'h0000;
         else if (m_owner != 0 && req_of(m_owner - 1))
            m_disp = (m_owner == 1) ? data0 : data1;

         if (nxt != m_owner) m_held = 0;
         else if (m_held < 1000) m_held++;
         m_owner = nxt;
         m_tick++;
      end
      e.g0 = (m_owner == 1);
      e.g1 = (m_owner == 2);
      e.dp = 1'b0;
      exp_q.push_back(e);
   endtask

   task automatic cycle(input logic r, input logic r0, input logic r1,
                        input logic [15:0] d0, input logic [15:0] d1);
      @(negedge clk);
      rst   = r;
      req0  = r0;
      req1  = r1;
      data0 = d0;
      data1 = d1;
      @(posedge clk);
      model_step();
      n_cycle++;
   endtask

   // Monitor: compare every presented output against the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      exp_t a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {gnt0, gnt1, seg, an, dp};
         check($sformatf("outs cyc%0d g0g1_seg_an_dp", n_cycle), 32'(a), 32'(e));
      end
   end

   initial begin
      logic r0, r1;
      logic [15:0] d0, d1;
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;

      // Reset, then idle with no requests.
      repeat (3)  cycle(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
      repeat (50) cycle(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);

      // Single requester showing 12AF, then letting go.
      repeat (20) cycle(1'b0, 1'b1, 1'b0, 16'h12AF, 16'h0);
      repeat (15) cycle(1'b0, 1'b0, 1'b0, 16'h12AF, 16'h0);

      // Simultaneous requests after reset; requester 0 drops early.
      repeat (2)  cycle(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
      repeat (3)  cycle(1'b0, 1'b1, 1'b1, 16'h3C5D, 16'h9E01);
      repeat (20) cycle(1'b0, 1'b0, 1'b1, 16'h3C5D, 16'h9E01);
      repeat (12) cycle(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);

      // Both keep re-requesting: each owner lets go shortly after its grant.
      for (int i = 0; i < 150; i++) begin
         r0 = !(m_owner == 1 && m_held >= 2);
         r1 = !(m_owner == 2 && m_held >= 2);
         cycle(1'b0, r0, r1, 16'($urandom), 16'($urandom));
      end
      repeat (12) cycle(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);

      // Reset while requester 1 owns; afterwards contention goes to 0.
      repeat (5)  cycle(1'b0, 1'b0, 1'b1, 16'h0, 16'hBEEF);
      cycle(1'b1, 1'b1, 1'b1, 16'h1111, 16'h2222);
      repeat (14) cycle(1'b0, 1'b1, 1'b1, 16'h1111, 16'h2222);
      repeat (20) cycle(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);

      // Value with leading zeros.
      repeat (24) cycle(1'b0, 1'b1, 1'b0, 16'h0007, 16'h0);
      repeat (12) cycle(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);

      // Random requests, including short pulses during the other's ownership.
      r0 = 1'b0; r1 = 1'b0; d0 = 16'h0; d1 = 16'h0;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 5) == 0) r0 = ~r0;
         if ($urandom_range(0, 5) == 0) r1 = ~r1;
         if ($urandom_range(0, 3) == 0) d0 = 16'($urandom);
         if ($urandom_range(0, 3) == 0) d1 = 16'($urandom & 32'h00FF);
         cycle(1'b0, r0, r1, d0, d1);
      end

      @(negedge clk);
      #1;
      check("scoreboard drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
